router_pkt_tx: RTL

Packet source for the 1x3 router input port. It accepts a packet request (destination address and payload length) and then buffers the payload bytes from an upstream byte stream. Once the payload is buffered, it drives the router's `pkt_valid` / `data_in` bus: header, then payload, then parity. It obeys the router's `busy` back-pressure and needs no other sideband. It sits between a traffic generator or host interface and the router top.

---
 rtl/router_pkt_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port: buffers a request's payload,
// then drives header, payload and parity on the router bus under busy back-pressure.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_addr,
    input  logic [5:0]  req_len,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [7:0]  pl_data,
    input  logic        busy,
    output logic        pkt_valid,
    output logic [7:0]  data_out,
    output logic        req_err,
    output logic        tx_done,
    output logic [15:0] tx_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_TAIL
    } state_t;

    state_t      state_reg;
    logic [1:0]  addr_reg;
    logic [5:0]  len_reg;
    logic [5:0]  wr_cnt_reg;
    logic [5:0]  rd_idx_reg;
    logic [7:0]  parity_reg;
    logic        pkt_valid_reg;
    logic [7:0]  data_out_reg;
    logic        req_err_reg;
    logic        tx_done_reg;
    logic [15:0] tx_count_reg;

    logic [7:0]  mem [0:MAX_LEN];
    logic [7:0]  header;
    logic        wr_en;

    assign header    = {len_reg, addr_reg};
    assign req_ready = (state_reg == S_IDLE);
    assign pl_ready  = (state_reg == S_COLLECT) && (wr_cnt_reg < len_reg);
    assign wr_en     = pl_valid && pl_ready;

    assign pkt_valid = pkt_valid_reg;
    assign data_out  = data_out_reg;
    assign req_err   = req_err_reg;
    assign tx_done   = tx_done_reg;
    assign tx_count  = tx_count_reg;

    // Payload storage carries no reset so it can map onto RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_cnt_reg] <= pl_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            addr_reg      <= 2'd0;
            len_reg       <= 6'd0;
            wr_cnt_reg    <= 6'd0;
            rd_idx_reg    <= 6'd0;
            parity_reg    <= 8'd0;
            pkt_valid_reg <= 1'b0;
            data_out_reg  <= 8'd0;
            req_err_reg   <= 1'b0;
            tx_done_reg   <= 1'b0;
            tx_count_reg  <= 16'd0;
        end else begin
            req_err_reg <= 1'b0;
            tx_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    pkt_valid_reg <= 1'b0;
                    data_out_reg  <= 8'd0;
                    if (req_valid) begin
                        if (req_addr == 2'd3) begin
                            req_err_reg <= 1'b1;
                        end else begin
                            addr_reg   <= req_addr;
                            len_reg    <= req_len;
                            parity_reg <= {req_len, req_addr};
                            wr_cnt_reg <= 6'd0;
                            state_reg  <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (len_reg == 6'd0) begin
                        data_out_reg  <= header;
                        pkt_valid_reg <= 1'b1;
                        state_reg     <= S_HEADER;
                    end else if (wr_en) begin
                        parity_reg <= parity_reg ^ pl_data;
                        wr_cnt_reg <= wr_cnt_reg + 6'd1;
                        if (wr_cnt_reg + 6'd1 == len_reg) begin
                            data_out_reg  <= header;
                            pkt_valid_reg <= 1'b1;
                            state_reg     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        if (len_reg != 6'd0) begin
                            data_out_reg <= mem[0];
                            rd_idx_reg   <= 6'd1;
                            state_reg    <= S_PAYLOAD;
                        end else begin
                            data_out_reg  <= parity_reg;
                            pkt_valid_reg <= 1'b0;
                            state_reg     <= S_PARITY;
                        end
                    end
                end
                S_PAYLOAD: begin
                    // Index advances only on a consumed byte, so stalls never skip data.
                    if (!busy) begin
                        if (rd_idx_reg < len_reg) begin
                            data_out_reg <= mem[rd_idx_reg];
                            rd_idx_reg   <= rd_idx_reg + 6'd1;
                        end else begin
                            data_out_reg  <= parity_reg;
                            pkt_valid_reg <= 1'b0;
                            state_reg     <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        data_out_reg <= 8'd0;
                        state_reg    <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    // Holding here while busy lets the router finish its parity check.
                    if (!busy) begin
                        tx_done_reg  <= 1'b1;
                        tx_count_reg <= tx_count_reg + 16'd1;
                        state_reg    <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
